// File: rtl/attention_rowmax_tile_if.sv
// attention_rowmax_tile_if: scaled-score read port (upstream)
// and row-max read port (downstream) of attention_rowmax_tile.
interface attention_rowmax_tile_if #(
  parameter int T = 4
);
  localparam int AW = $clog2(T);

  logic          s_rd_en;
  logic          s_rd_re;
  logic [AW-1:0] s_rd_row;
  logic [AW-1:0] s_rd_col;
  logic [31:0]   s_rd_rdata;
  logic          s_rd_rvalid;
  logic          m_rd_re;
  logic [AW-1:0] m_rd_row;
  logic [31:0]   m_rd_rdata;
  logic          m_rd_rvalid;

  modport master (
    output s_rd_en,
    output s_rd_re,
    output s_rd_row,
    output s_rd_col,
    input  s_rd_rdata,
    input  s_rd_rvalid,
    input  m_rd_re,
    input  m_rd_row,
    output m_rd_rdata,
    output m_rd_rvalid
  );

  modport slave (
    input  s_rd_en,
    input  s_rd_re,
    input  s_rd_row,
    input  s_rd_col,
    output s_rd_rdata,
    output s_rd_rvalid,
    output m_rd_re,
    output m_rd_row,
    input  m_rd_rdata,
    input  m_rd_rvalid
  );
endinterface

// File: rtl/attention_rowmax_tile.sv
// attention_rowmax_tile: per-row FP32 maximum of the scaled
// score tile, optional causal mask, NaN rows forced to qNaN.
module attention_rowmax_tile #(
  parameter int T      = 4,
  parameter int DATA_W = 32,
  parameter bit CAUSAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic M_valid,
  attention_rowmax_tile_if.master ifc
);
  localparam int AW = $clog2(T);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;
  localparam logic [AW-1:0] LAST = AW'(T - 1);
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

  logic [1:0]        state;
  logic [AW-1:0]     row;
  logic [AW-1:0]     col;
  logic [DATA_W-1:0] run_max;
  logic              run_nan;
  logic              mv_q;
  logic [DATA_W-1:0] mem [T];

  logic              accept;
  logic              row_end;
  logic              pass_end;
  logic              in_nan;
  logic              take;
  logic              res_nan;
  logic [DATA_W-1:0] new_max;
  logic [DATA_W-1:0] row_res;

  function automatic logic [DATA_W-1:0] okey(
    input logic [DATA_W-1:0] v
  );
    return v[DATA_W-1] ? ~v
                       : v ^ {1'b1, {(DATA_W-1){1'b0}}};
  endfunction

  // element acceptance and next running max / NaN state
  always_comb begin
    accept   = (state == S_WAIT) && ifc.s_rd_rvalid;
    row_end  = CAUSAL ? (col == row) : (col == LAST);
    pass_end = row_end && (row == LAST);
    in_nan   = (&ifc.s_rd_rdata[30:23])
            && (|ifc.s_rd_rdata[22:0]);
    take     = (col == '0)
            || (okey(ifc.s_rd_rdata) > okey(run_max));
    new_max  = take ? ifc.s_rd_rdata : run_max;
    res_nan  = run_nan || in_nan;
    row_res  = res_nan ? QNAN : new_max;
  end

  // status and upstream request outputs decoded from state
  always_comb begin
    busy         = (state == S_REQ) || (state == S_WAIT);
    done         = (state == S_FIN);
    M_valid      = mv_q;
    ifc.s_rd_en  = busy;
    ifc.s_rd_re  = (state == S_REQ);
    ifc.s_rd_row = row;
    ifc.s_rd_col = col;
  end

  // pass sequencing, scan counters and running row state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      run_max <= '0;
      run_nan <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_REQ;
            row     <= '0;
            col     <= '0;
            run_max <= '0;
            run_nan <= 1'b0;
            mv_q    <= 1'b0;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (accept) begin
            if (row_end) begin
              run_max <= '0;
              run_nan <= 1'b0;
              col     <= '0;
              row     <= pass_end ? '0 : row + 1'b1;
            end else begin
              run_max <= new_max;
              run_nan <= res_nan;
              col     <= col + 1'b1;
            end
            if (pass_end) begin
              state <= S_FIN;
              mv_q  <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // row-max buffer: one write per finished row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < T; i++) mem[i] <= '0;
    end else if (accept && row_end) begin
      mem[row] <= row_res;
    end
  end

  // registered row-max read, serviced in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifc.m_rd_rdata  <= '0;
      ifc.m_rd_rvalid <= 1'b0;
    end else begin
      ifc.m_rd_rvalid <= ifc.m_rd_re;
      if (ifc.m_rd_re) begin
        ifc.m_rd_rdata <= (int'(ifc.m_rd_row) < T)
                        ? mem[ifc.m_rd_row] : '0;
      end
    end
  end
endmodule

// File: tb/tb_attention_rowmax_tile.sv
// tb_attention_rowmax_tile: random and directed passes on a
// full and a causal instance, checked against a row-max model.
module tb_attention_rowmax_tile;
  localparam int T = 4;
  localparam logic [31:0] RAMP [16] = '{
    32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
    32'h40200000, 32'h40400000, 32'h40600000, 32'h40800000,
    32'h40900000, 32'h40A00000, 32'h40B00000, 32'h40C00000,
    32'h40D00000, 32'h40E00000, 32'h40F00000, 32'h41000000};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy0, done0, mv0;
  logic busy1, done1, mv1;
  logic [31:0] mat [T][T];
  int lat = 2;
  bit stray = 1'b0;
  int tests = 0;
  int fails = 0;
  int dc0, dc1, rc1;
  int cd0 = 0, cd1 = 0;
  int q0r, q0c, q1r, q1c;

  always #5 clk = ~clk;

  attention_rowmax_tile_if #(.T(T)) b0 ();
  attention_rowmax_tile_if #(.T(T)) b1 ();

  attention_rowmax_tile #(.T(T), .DATA_W(32), .CAUSAL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy0), .done(done0), .M_valid(mv0), .ifc(b0));

  attention_rowmax_tile #(.T(T), .DATA_W(32), .CAUSAL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy1), .done(done1), .M_valid(mv1), .ifc(b1));

  // upstream scaling-tile models: data L cycles after the request
  always @(negedge clk) begin
    b0.s_rd_rvalid = 1'b0;
    if (!rst_n) cd0 = 0;
    if (cd0 > 0) begin
      cd0--;
      if (cd0 == 0) begin
        b0.s_rd_rvalid = 1'b1;
        b0.s_rd_rdata  = mat[q0r][q0c];
      end
    end
    if (b0.s_rd_re) begin
      cd0 = lat;
      q0r = int'(b0.s_rd_row);
      q0c = int'(b0.s_rd_col);
      if (stray) begin
        b0.s_rd_rvalid = 1'b1;
        b0.s_rd_rdata  = 32'h7F7FFFFF;
      end
    end
  end

  always @(negedge clk) begin
    b1.s_rd_rvalid = 1'b0;
    if (!rst_n) cd1 = 0;
    if (cd1 > 0) begin
      cd1--;
      if (cd1 == 0) begin
        b1.s_rd_rvalid = 1'b1;
        b1.s_rd_rdata  = mat[q1r][q1c];
      end
    end
    if (b1.s_rd_re) begin
      cd1 = lat;
      q1r = int'(b1.s_rd_row);
      q1c = int'(b1.s_rd_col);
      if (stray) begin
        b1.s_rd_rvalid = 1'b1;
        b1.s_rd_rdata  = 32'h7F7FFFFF;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // IEEE ordering: positive beats negative, +0 beats -0
  function automatic bit fgt(input logic [31:0] a,
                             input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic bit fnan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] golden(input int r,
                                         input bit cz);
    logic [31:0] m;
    bit nan;
    int last;
    last = cz ? r : T - 1;
    m = mat[r][0];
    nan = 1'b0;
    for (int c = 0; c <= last; c++) begin
      if (fnan(mat[r][c])) nan = 1'b1;
      if (c > 0 && fgt(mat[r][c], m)) m = mat[r][c];
    end
    return nan ? 32'h7FC00000 : m;
  endfunction

  task automatic elem(input int j, input bit cz,
                      output int er, output int ec);
    int n;
    n = 0;
    er = 0;
    ec = 0;
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++)
        if (!cz || c <= r) begin
          if (n == j) begin
            er = r;
            ec = c;
          end
          n++;
        end
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0: v = {v[31], 8'hFF, v[22:1], 1'b1};
      1: v = {v[31], 31'd0};
      2: v = {v[31], 8'hFF, 23'd0};
      3, 4: v = {v[31], 8'h80, 20'd0, v[2:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) mat[r][c] = RAMP[r*T + c];
  endtask

  task automatic fill_rand();
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) mat[r][c] = rnd_val();
  endtask

  task automatic cyc_chk(input int k, input bit cz,
                         input logic bsy, input logic dn,
                         input logic mv, input logic en,
                         input logic re, input logic [1:0] row,
                         input logic [1:0] col);
    int n, fin, j, er, ec;
    bit req;
    string tg;
    n   = cz ? T * (T + 1) / 2 : T * T;
    fin = n * (lat + 1) + 1;
    j   = (k - 1) / (lat + 1);
    req = ((k - 1) % (lat + 1) == 0) && (j < n);
    tg  = cz ? "c1" : "c0";
    chk({tg, ".busy"}, bsy, k < fin);
    chk({tg, ".done"}, dn, k == fin);
    chk({tg, ".M_valid"}, mv, k >= fin);
    chk({tg, ".s_rd_en"}, en, k < fin);
    chk({tg, ".s_rd_re"}, re, req);
    if (req) begin
      elem(j, cz, er, ec);
      chk({tg, ".s_rd_row"}, row, er);
      chk({tg, ".s_rd_col"}, col, ec);
    end
  endtask

  task automatic rst_chk(input string tg);
    chk({tg, ".c0.busy"}, busy0, 1'b0);
    chk({tg, ".c0.done"}, done0, 1'b0);
    chk({tg, ".c0.M_valid"}, mv0, 1'b0);
    chk({tg, ".c0.en"}, b0.s_rd_en, 1'b0);
    chk({tg, ".c0.re"}, b0.s_rd_re, 1'b0);
    chk({tg, ".c0.row"}, b0.s_rd_row, 2'd0);
    chk({tg, ".c0.col"}, b0.s_rd_col, 2'd0);
    chk({tg, ".c0.m_rvalid"}, b0.m_rd_rvalid, 1'b0);
    chk({tg, ".c0.m_rdata"}, b0.m_rd_rdata, 32'd0);
    chk({tg, ".c1.busy"}, busy1, 1'b0);
    chk({tg, ".c1.done"}, done1, 1'b0);
    chk({tg, ".c1.M_valid"}, mv1, 1'b0);
    chk({tg, ".c1.en"}, b1.s_rd_en, 1'b0);
    chk({tg, ".c1.re"}, b1.s_rd_re, 1'b0);
    chk({tg, ".c1.m_rvalid"}, b1.m_rd_rvalid, 1'b0);
    chk({tg, ".c1.m_rdata"}, b1.m_rd_rdata, 32'd0);
  endtask

  task automatic read_all(input bit zero);
    for (int r = 0; r <= T; r++) begin
      @(negedge clk);
      if (r > 0) begin
        chk("c0.rd_rvalid", b0.m_rd_rvalid, 1'b1);
        chk("c0.rd_rdata", b0.m_rd_rdata,
            zero ? 32'd0 : golden(r - 1, 1'b0));
        chk("c1.rd_rvalid", b1.m_rd_rvalid, 1'b1);
        chk("c1.rd_rdata", b1.m_rd_rdata,
            zero ? 32'd0 : golden(r - 1, 1'b1));
      end
      b0.m_rd_re  = (r < T);
      b0.m_rd_row = 2'(r);
      b1.m_rd_re  = (r < T);
      b1.m_rd_row = 2'(r);
    end
    @(negedge clk);
    chk("c0.rd_idle", b0.m_rd_rvalid, 1'b0);
    chk("c1.rd_idle", b1.m_rd_rvalid, 1'b0);
  endtask

  task automatic run_pass(input int restart_at, input int abort_at);
    int fin0, e0, e1;
    fin0 = T * T * (lat + 1) + 1;
    e0 = T * (lat + 1) + 1;
    e1 = (lat + 1) + 1;
    dc0 = -1;
    dc1 = -1;
    rc1 = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= fin0 + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        rst_chk("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
          @(negedge clk);
          chk("post.c0.re", b0.s_rd_re, 1'b0);
          chk("post.c0.busy", busy0, 1'b0);
          chk("post.c0.M_valid", mv0, 1'b0);
          chk("post.c1.re", b1.s_rd_re, 1'b0);
          chk("post.c1.M_valid", mv1, 1'b0);
        end
        return;
      end
      cyc_chk(k, 1'b0, busy0, done0, mv0, b0.s_rd_en,
              b0.s_rd_re, b0.s_rd_row, b0.s_rd_col);
      cyc_chk(k, 1'b1, busy1, done1, mv1, b1.s_rd_en,
              b1.s_rd_re, b1.s_rd_row, b1.s_rd_col);
      if (done0 && dc0 < 0) dc0 = k;
      if (done1 && dc1 < 0) dc1 = k;
      if (b1.s_rd_re) rc1++;
      if (k == e0 + 1) begin
        chk("c0.early_rvalid", b0.m_rd_rvalid, 1'b1);
        chk("c0.early_rdata", b0.m_rd_rdata, golden(0, 1'b0));
        b0.m_rd_re = 1'b0;
      end
      if (k == e0) begin
        b0.m_rd_re  = 1'b1;
        b0.m_rd_row = 2'd0;
      end
      if (k == e1 + 1) begin
        chk("c1.early_rvalid", b1.m_rd_rvalid, 1'b1);
        chk("c1.early_rdata", b1.m_rd_rdata, golden(0, 1'b1));
        b1.m_rd_re = 1'b0;
      end
      if (k == e1) begin
        b1.m_rd_re  = 1'b1;
        b1.m_rd_row = 2'd0;
      end
      start = (k == restart_at);
    end
    start = 1'b0;
  endtask

  initial begin
    b0.m_rd_re  = 1'b0;
    b0.m_rd_row = 2'd0;
    b1.m_rd_re  = 1'b0;
    b1.m_rd_row = 2'd0;
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst_n = 1'b1;
    read_all(1'b1);

    fill_ramp();
    chk("pin.full.r0", golden(0, 1'b0), 32'h40000000);
    chk("pin.full.r1", golden(1, 1'b0), 32'h40800000);
    chk("pin.full.r2", golden(2, 1'b0), 32'h40C00000);
    chk("pin.full.r3", golden(3, 1'b0), 32'h41000000);
    chk("pin.causal.r0", golden(0, 1'b1), 32'h3F000000);
    chk("pin.causal.r1", golden(1, 1'b1), 32'h40400000);
    chk("pin.causal.r2", golden(2, 1'b1), 32'h40B00000);
    chk("pin.causal.r3", golden(3, 1'b1), 32'h41000000);
    lat = 2;
    run_pass(0, 0);
    chk("c0.done_cycle", dc0, 49);
    chk("c1.done_cycle", dc1, 31);
    chk("c1.re_count", rc1, 10);
    read_all(1'b0);

    mat[0] = '{32'hBF800000, 32'hC0400000, 32'h80000000, 32'h00000000};
    mat[1] = '{32'hC0000000, 32'hBF800000, 32'hC0800000, 32'hC1000000};
    mat[2] = '{32'hFF800000, 32'hC0A00000, 32'hFF800000, 32'hC0C00000};
    mat[3] = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h40000000};
    chk("pin.zero", golden(0, 1'b0), 32'h00000000);
    chk("pin.neg", golden(1, 1'b0), 32'hBF800000);
    chk("pin.ninf", golden(2, 1'b0), 32'hC0A00000);
    chk("pin.tie", golden(3, 1'b0), 32'h40400000);
    run_pass(0, 0);
    read_all(1'b0);

    fill_ramp();
    mat[1][1] = 32'h7FC00001;
    chk("pin.nan.full", golden(1, 1'b0), 32'h7FC00000);
    chk("pin.nan.causal", golden(1, 1'b1), 32'h7FC00000);
    chk("pin.nan.other", golden(2, 1'b0), 32'h40C00000);
    run_pass(0, 0);
    read_all(1'b0);

    foreach (RAMP[i]) begin
      if (i == 1 || i == 4) begin
        lat = i;
        fill_rand();
        run_pass(0, 0);
        chk("c0.done_cycle_L", dc0, 16 * (lat + 1) + 1);
        read_all(1'b0);
      end
    end

    lat = 3;
    fill_rand();
    run_pass(5, 0);
    read_all(1'b0);

    lat = 2;
    stray = 1'b1;
    fill_rand();
    run_pass(0, 0);
    stray = 1'b0;
    read_all(1'b0);

    repeat (4) begin
      lat = $urandom_range(1, 5);
      fill_rand();
      run_pass(0, 0);
      read_all(1'b0);
    end

    lat = 2;
    fill_ramp();
    run_pass(0, 27);
    read_all(1'b1);
    run_pass(0, 0);
    read_all(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
